// File: rtl/grid_io_multi_cfg_if.sv
// Bundle of the configuration-chain and pad/fabric signals of one IO tile.
// The master side drives the chain and the pad/fabric inputs. The slave side is the tile itself.
interface grid_io_multi_cfg_if #(
    parameter int NUM_IO = 4
);
    logic              ccff_en;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_commit;
    logic              cfg_done;
    logic              cfg_err;
    logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_IN;
    logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_OUT;
    logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_DIR;
    logic [NUM_IO-1:0] right_pin_outpad;
    logic [NUM_IO-1:0] right_pin_inpad;

    modport master (
        output ccff_en, ccff_head, ccff_commit,
        output gfpga_pad_EMBEDDED_IO_SOC_IN, right_pin_outpad,
        input  ccff_tail, cfg_done, cfg_err,
        input  gfpga_pad_EMBEDDED_IO_SOC_OUT, gfpga_pad_EMBEDDED_IO_SOC_DIR, right_pin_inpad
    );

    modport slave (
        input  ccff_en, ccff_head, ccff_commit,
        input  gfpga_pad_EMBEDDED_IO_SOC_IN, right_pin_outpad,
        output ccff_tail, cfg_done, cfg_err,
        output gfpga_pad_EMBEDDED_IO_SOC_OUT, gfpga_pad_EMBEDDED_IO_SOC_DIR, right_pin_inpad
    );
endinterface

// File: rtl/grid_io_multi_cfg.sv
// IO tile with NUM_IO pad channels. Each channel is configured as {reg, inv, dir}.
// The configuration shifts serially into a shadow chain. It is copied into the live (active)
// configuration only when a commit arrives after exactly L shifts, so the pads never see a
// partially loaded configuration.
module grid_io_multi_cfg #(
    parameter int NUM_IO = 4
) (
    input  logic               prog_clk,
    input  logic               prog_reset_n,
    grid_io_multi_cfg_if.slave bus
);
    localparam int CFG_BITS = 3;
    localparam int L        = NUM_IO * CFG_BITS;
    localparam int CW       = $clog2(L + 2);
    localparam logic [CW-1:0] C_LEN  = CW'(L);
    localparam logic [CW-1:0] C_OVER = CW'(L + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARMED} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              w_commit_ok;
    logic              w_commit_bad;
    logic              r_cfg_done;
    logic              r_cfg_err;
    logic [L-1:0]      r_shadow;
    logic [L-1:0]      r_active;
    logic [NUM_IO-1:0] w_dir;
    logic [NUM_IO-1:0] w_inv;
    logic [NUM_IO-1:0] w_reg;
    logic [NUM_IO-1:0] w_o;
    logic [NUM_IO-1:0] w_i;
    logic [NUM_IO-1:0] r_oq;
    logic [NUM_IO-1:0] r_iq;

    // Count-driven load FSM: a shift takes priority over a simultaneous commit
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_commit_ok  = 1'b0;
        w_commit_bad = 1'b0;
        if (bus.ccff_en) begin
            w_count_nxt = (r_count == C_OVER) ? C_OVER : r_count + 1'b1;
            w_state_nxt = (w_count_nxt == C_LEN) ? S_ARMED : S_LOAD;
        end else if (bus.ccff_commit) begin
            w_count_nxt = '0;
            w_state_nxt = S_IDLE;
            if (r_state == S_ARMED) begin
                w_commit_ok = 1'b1;
            end else begin
                w_commit_bad = 1'b1;
            end
        end
    end

    // FSM state, shift count, and the done pulse / sticky error flags
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_cfg_done <= w_commit_ok;
            if (w_commit_ok) begin
                r_cfg_err <= 1'b0;
            end else if (w_commit_bad) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    // Shadow chain: a commit does not clear it; it changes only on a shift or a reset
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            r_shadow <= '0;
        end else if (bus.ccff_en) begin
            r_shadow <= {r_shadow[L-2:0], bus.ccff_head};
        end
    end

    // Active configuration: all channels switch together on a good commit
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            r_active <= '0;
        end else if (w_commit_ok) begin
            r_active <= r_shadow;
        end
    end

    // Unpack the active configuration into per-channel fields and apply the polarity
    always_comb begin
        w_dir = '0;
        w_inv = '0;
        w_reg = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            w_dir[k] = r_active[CFG_BITS*k];
            w_inv[k] = r_active[CFG_BITS*k+1];
            w_reg[k] = r_active[CFG_BITS*k+2];
        end
        w_o = bus.right_pin_outpad ^ w_inv;
        w_i = bus.gfpga_pad_EMBEDDED_IO_SOC_IN ^ w_inv;
    end

    // Pad registers sample every cycle; they are used only by channels with reg=1
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            r_oq <= '0;
            r_iq <= '0;
        end else begin
            r_oq <= w_o;
            r_iq <= w_i;
        end
    end

    assign bus.ccff_tail                     = r_shadow[L-1];
    assign bus.cfg_done                      = r_cfg_done;
    assign bus.cfg_err                       = r_cfg_err;
    assign bus.gfpga_pad_EMBEDDED_IO_SOC_DIR = w_dir;
    assign bus.gfpga_pad_EMBEDDED_IO_SOC_OUT = w_dir & ((w_reg & r_oq) | (~w_reg & w_o));
    assign bus.right_pin_inpad               = ~w_dir & ((w_reg & r_iq) | (~w_reg & w_i));

endmodule

// File: tb/tb_grid_io_multi_cfg.sv
// Bench for grid_io_multi_cfg (NUM_IO=4).
// Chain pass-through bits go through a timed expectation queue.
// Configuration, commit, and pad behaviour are checked against hand-derived constants.
module tb_grid_io_multi_cfg;
    localparam int NUM_IO = 4;
    localparam int L      = 12;

    logic prog_clk     = 1'b0;
    logic prog_reset_n = 1'b0;

    grid_io_multi_cfg_if #(.NUM_IO(NUM_IO)) bus ();

    grid_io_multi_cfg #(.NUM_IO(NUM_IO)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .bus          (bus.slave)
    );

    always #5 prog_clk = ~prog_clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        int   due;
        logic b;
    } tail_exp_t;

    tail_exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter used to time the tail expectations
    always @(posedge prog_clk) cyc <= cyc + 1;

    // Compare the tail against each queued bit when it is due
    always @(negedge prog_clk) begin : tail_mon
        tail_exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("tail_passthru", {31'd0, bus.ccff_tail}, {31'd0, e.b});
        end
    end

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Shift w[n-1] first, down to w[0], one bit per cycle with no gaps
    task automatic shift_bits(input logic [31:0] w, input int n, input bit track);
        tail_exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            bus.ccff_en   = 1'b1;
            bus.ccff_head = w[i];
            if (track) begin
                e.due = cyc + L;
                e.b   = w[i];
                sb_q.push_back(e);
            end
            step();
        end
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
    endtask

    task automatic commit();
        bus.ccff_commit = 1'b1;
        step();
        bus.ccff_commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ccff_en                      = 1'b0;
        bus.ccff_head                    = 1'b0;
        bus.ccff_commit                  = 1'b0;
        bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'b1010;
        bus.right_pin_outpad             = 4'b0000;
        repeat (3) step();

        // Reset state: input pads pass straight through to the fabric
        chk("rst_inpad", 32'(bus.right_pin_inpad), 32'h0000_000A);
        chk("rst_dir",   32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h0);
        chk("rst_out",   32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'h0);
        chk("rst_err",   32'(bus.cfg_err), 32'h0);
        chk("rst_done",  32'(bus.cfg_done), 32'h0);
        chk("rst_tail",  32'(bus.ccff_tail), 32'h0);
        prog_reset_n = 1'b1;
        step();

        // ch0 = {reg0, inv0, dir1}; all other channels are inputs
        shift_bits(32'h001, 12, 1'b0);
        commit();
        chk("c2_done", 32'(bus.cfg_done), 32'h1);
        chk("c2_dir",  32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h1);
        chk("c2_err",  32'(bus.cfg_err), 32'h0);
        bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'b1111;
        bus.right_pin_outpad             = 4'b0001;
        #1;
        chk("c2_out_comb", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'h1);
        chk("c2_inpad",    32'(bus.right_pin_inpad), 32'hE);
        step();
        chk("c2_done_pulse", 32'(bus.cfg_done), 32'h0);

        // ch2 = {reg1, inv1, dir0}; ch0 stays an output
        shift_bits(32'h181, 12, 1'b0);
        commit();
        chk("c3_done", 32'(bus.cfg_done), 32'h1);
        bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'b1011;
        bus.right_pin_outpad             = 4'b0000;
        step();
        step();
        chk("c3_inpad_pre", 32'(bus.right_pin_inpad), 32'hE);
        bus.gfpga_pad_EMBEDDED_IO_SOC_IN = 4'b1111;
        #1;
        chk("c3_inpad_hold", 32'(bus.right_pin_inpad), 32'hE);
        step();
        chk("c3_inpad_lat", 32'(bus.right_pin_inpad), 32'hA);

        // Length checking: 11 shifts and 13 shifts are rejected; 12 shifts are accepted
        shift_bits(32'h249, 11, 1'b0);
        commit();
        chk("c4_short_err", 32'(bus.cfg_err), 32'h1);
        chk("c4_short_dir", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h1);
        chk("c4_short_done", 32'(bus.cfg_done), 32'h0);
        shift_bits(32'h249, 13, 1'b0);
        commit();
        chk("c4_long_err", 32'(bus.cfg_err), 32'h1);
        chk("c4_long_dir", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h1);
        shift_bits(32'h249, 12, 1'b0);
        commit();
        chk("c4_ok_err",  32'(bus.cfg_err), 32'h0);
        chk("c4_ok_done", 32'(bus.cfg_done), 32'h1);
        chk("c4_ok_dir",  32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'hF);

        // A commit that coincides with the 12th shift is ignored.
        // Config: ch0 = {reg1, inv0, dir1}, ch1 = {reg0, inv0, dir1}.
        shift_bits(32'h006, 11, 1'b0);
        bus.ccff_en     = 1'b1;
        bus.ccff_head   = 1'b1;
        bus.ccff_commit = 1'b1;
        step();
        bus.ccff_en     = 1'b0;
        bus.ccff_head   = 1'b0;
        bus.ccff_commit = 1'b0;
        chk("c5_same_done", 32'(bus.cfg_done), 32'h0);
        chk("c5_same_dir",  32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'hF);
        commit();
        chk("c5_done", 32'(bus.cfg_done), 32'h1);
        chk("c5_dir",  32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h3);
        bus.right_pin_outpad = 4'b0000;
        step();
        chk("c5_out_zero", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'h0);
        bus.right_pin_outpad = 4'b0001;
        #1;
        chk("c5_out_hold", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'h0);
        step();
        chk("c5_out_reg", 32'(bus.gfpga_pad_EMBEDDED_IO_SOC_OUT), 32'h1);

        // Chain pass-through of 0xA5C, followed by a reset in the middle of a shift
        shift_bits(32'hA5C, 12, 1'b1);
        shift_bits(32'hFFF, 12, 1'b0);
        chk("c6_sb_drained", 32'(sb_q.size()), 32'h0);
        shift_bits(32'h3F, 6, 1'b0);
        chk("c6_pre_tail", 32'(bus.ccff_tail), 32'h1);
        chk("c6_pre_dir",  32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h3);
        prog_reset_n = 1'b0;
        step();
        chk("c6_rst_count", 32'(dut.r_count), 32'h0);
        chk("c6_rst_dir",   32'(bus.gfpga_pad_EMBEDDED_IO_SOC_DIR), 32'h0);
        chk("c6_rst_tail",  32'(bus.ccff_tail), 32'h0);
        prog_reset_n = 1'b1;
        step();
        commit();
        chk("c6_post_err",  32'(bus.cfg_err), 32'h1);
        chk("c6_post_done", 32'(bus.cfg_done), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
